// File: rtl/uart_tx.sv
// UART transmitter: serialises valid/ready-accepted words into start/data/parity/stop frames on tx.
// Bit cells are OVERSAMPLING clk cycles long, matching uart_rx timing.
module uart_tx #(
  parameter int DATA_BITS    = 8,
  parameter int STOP_BITS    = 1,
  parameter int OVERSAMPLING = 16,
  parameter int PARITY       = 0
) (
  input  logic                 clk,
  input  logic                 n_rst,
  input  logic                 valid_in,
  input  logic [DATA_BITS-1:0] data_in,
  output logic                 ready_out,
  output logic                 tx,
  output logic                 busy_out,
  output logic                 done_out
);

  localparam int CW = $clog2(STOP_BITS * OVERSAMPLING);
  localparam int BW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] CELL_LAST = CW'(OVERSAMPLING - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS * OVERSAMPLING - 1);
  localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t               state, state_n;
  logic [CW-1:0]        clk_cnt, clk_cnt_n;
  logic [BW-1:0]        bit_cnt, bit_cnt_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic                 par_bit, par_bit_n;
  logic                 tx_n, done_n;

  assign ready_out = (state == S_IDLE);
  assign busy_out  = ~ready_out;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state    <= S_IDLE;
      clk_cnt  <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      done_out <= 1'b0;
    end else begin
      state    <= state_n;
      clk_cnt  <= clk_cnt_n;
      bit_cnt  <= bit_cnt_n;
      shift    <= shift_n;
      par_bit  <= par_bit_n;
      tx       <= tx_n;
      done_out <= done_n;
    end
  end

  // The parity bit is captured at acceptance because the shift register is consumed while sending.
  always_comb begin
    state_n   = state;
    clk_cnt_n = clk_cnt + 1'b1;
    bit_cnt_n = bit_cnt;
    shift_n   = shift;
    par_bit_n = par_bit;
    tx_n      = tx;
    done_n    = 1'b0;
    case (state)
      S_IDLE: begin
        clk_cnt_n = '0;
        tx_n      = 1'b1;
        if (valid_in) begin
          shift_n   = data_in;
          par_bit_n = (PARITY == 2) ? ~(^data_in) : ^data_in;
          bit_cnt_n = '0;
          tx_n      = 1'b0;
          state_n   = S_START;
        end
      end
      S_START: begin
        if (clk_cnt == CELL_LAST) begin
          clk_cnt_n = '0;
          tx_n      = shift[0];
          shift_n   = shift >> 1;
          state_n   = S_DATA;
        end
      end
      S_DATA: begin
        if (clk_cnt == CELL_LAST) begin
          clk_cnt_n = '0;
          if (bit_cnt == BIT_LAST) begin
            bit_cnt_n = '0;
            if (PARITY != 0) begin
              tx_n    = par_bit;
              state_n = S_PARITY;
            end else begin
              tx_n    = 1'b1;
              state_n = S_STOP;
            end
          end else begin
            bit_cnt_n = bit_cnt + 1'b1;
            tx_n      = shift[0];
            shift_n   = shift >> 1;
          end
        end
      end
      S_PARITY: begin
        if (clk_cnt == CELL_LAST) begin
          clk_cnt_n = '0;
          tx_n      = 1'b1;
          state_n   = S_STOP;
        end
      end
      S_STOP: begin
        if (clk_cnt == STOP_LAST) begin
          clk_cnt_n = '0;
          done_n    = 1'b1;
          state_n   = S_IDLE;
        end
      end
      default: begin
        clk_cnt_n = '0;
        tx_n      = 1'b1;
        state_n   = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus queues expected frames, per-instance monitors decode tx and compare.
// Four instances cover default, even parity, odd parity and a short 7-bit/2-stop/4x configuration.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       n_rst = 1'b0;
  logic [3:0] valid_v = '0;
  logic [8:0] data_v [4];
  wire  [3:0] ready_v, tx_v, busy_v, done_v;
  int         cyc = 0;
  int         checks = 0;
  int         passes = 0;

  typedef struct packed {
    logic [31:0] k;
    logic [8:0]  word;
    logic        par;
  } exp_t;

  exp_t q0[$], q1[$], q2[$], q3[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_tx u0 (.clk(clk), .n_rst(n_rst), .valid_in(valid_v[0]), .data_in(data_v[0][7:0]),
              .ready_out(ready_v[0]), .tx(tx_v[0]), .busy_out(busy_v[0]), .done_out(done_v[0]));
  uart_tx #(.PARITY(1)) u1 (.clk(clk), .n_rst(n_rst), .valid_in(valid_v[1]), .data_in(data_v[1][7:0]),
              .ready_out(ready_v[1]), .tx(tx_v[1]), .busy_out(busy_v[1]), .done_out(done_v[1]));
  uart_tx #(.PARITY(2)) u2 (.clk(clk), .n_rst(n_rst), .valid_in(valid_v[2]), .data_in(data_v[2][7:0]),
              .ready_out(ready_v[2]), .tx(tx_v[2]), .busy_out(busy_v[2]), .done_out(done_v[2]));
  uart_tx #(.DATA_BITS(7), .STOP_BITS(2), .OVERSAMPLING(4)) u3 (.clk(clk), .n_rst(n_rst),
              .valid_in(valid_v[3]), .data_in(data_v[3][6:0]), .ready_out(ready_v[3]),
              .tx(tx_v[3]), .busy_out(busy_v[3]), .done_out(done_v[3]));

  function automatic void qPush(input int idx, input exp_t e);
    case (idx)
      0: q0.push_back(e);
      1: q1.push_back(e);
      2: q2.push_back(e);
      default: q3.push_back(e);
    endcase
  endfunction

  function automatic int qSize(input int idx);
    case (idx)
      0: return q0.size();
      1: return q1.size();
      2: return q2.size();
      default: return q3.size();
    endcase
  endfunction

  function automatic exp_t qPop(input int idx);
    exp_t r;
    case (idx)
      0: r = q0.pop_front();
      1: r = q1.pop_front();
      2: r = q2.pop_front();
      default: r = q3.pop_front();
    endcase
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual === expected) passes++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
  endtask

  // Offers a word and records the edge at which it will be accepted; data is scrambled afterwards.
  task automatic applyStimulus(input int idx, input logic [8:0] word, input logic par,
                               input int exp_k, input bit keep_valid, output int k);
    int   waited;
    exp_t e;
    waited = 0;
    k = -1;
    @(negedge clk);
    valid_v[idx] = 1'b1;
    data_v[idx]  = word;
    while (ready_v[idx] !== 1'b1 && waited < 2000) begin
      @(negedge clk);
      waited++;
    end
    if (ready_v[idx] !== 1'b1) begin
      checkOutput($sformatf("u%0d_accept_timeout", idx), 32'd0, 32'd1);
      valid_v[idx] = 1'b0;
      return;
    end
    k = cyc + 1;
    e.k    = (exp_k >= 0) ? exp_k : k;
    e.word = word;
    e.par  = par;
    qPush(idx, e);
    @(negedge clk);
    if (!keep_valid) valid_v[idx] = 1'b0;
    data_v[idx] = ~word;
  endtask

  task automatic waitIdle();
    int t;
    t = 0;
    while (!(ready_v == 4'hF && qSize(0) == 0 && qSize(1) == 0 && qSize(2) == 0 && qSize(3) == 0)
           && t < 5000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 5000) checkOutput("idle_timeout", 32'd0, 32'd1);
    repeat (20) @(negedge clk);
  endtask

  // Decodes one frame per start bit, checking every cycle of every cell plus the done/ready timing.
  task automatic frameMonitor(input int idx, input int db, input int sb, input int os, input int par);
    int          nf, s;
    exp_t        e;
    logic [15:0] bits;
    bit          aborted, cell_ok, ctl_ok;
    nf = 1 + db + ((par != 0) ? 1 : 0) + sb;
    forever begin
      while (!(n_rst === 1'b1 && tx_v[idx] === 1'b0)) @(negedge clk);
      s = cyc;
      if (qSize(idx) == 0) begin
        checkOutput($sformatf("u%0d_unexpected_frame", idx), 32'd1, 32'd0);
        repeat (nf * os) @(negedge clk);
        continue;
      end
      e = qPop(idx);
      checkOutput($sformatf("u%0d_start_edge", idx), s, e.k);
      bits    = '1;
      bits[0] = 1'b0;
      for (int i = 0; i < db; i++) bits[1+i] = e.word[i];
      if (par != 0) bits[1+db] = e.par;
      aborted = 1'b0;
      ctl_ok  = 1'b1;
      for (int c = 0; c < nf && !aborted; c++) begin
        cell_ok = 1'b1;
        for (int j = 0; j < os; j++) begin
          if (c != 0 || j != 0) @(negedge clk);
          if (n_rst !== 1'b1) begin
            aborted = 1'b1;
            break;
          end
          if (tx_v[idx] !== bits[c]) cell_ok = 1'b0;
          if (ready_v[idx] !== 1'b0 || busy_v[idx] !== 1'b1 || done_v[idx] !== 1'b0) ctl_ok = 1'b0;
        end
        if (!aborted) checkOutput($sformatf("u%0d_cell%0d_word%0h", idx, c, e.word), cell_ok, 32'd1);
      end
      if (!aborted) begin
        checkOutput($sformatf("u%0d_busy_flags", idx), ctl_ok, 32'd1);
        @(negedge clk);
        checkOutput($sformatf("u%0d_ready_done_tx_end", idx),
                    {ready_v[idx], done_v[idx], tx_v[idx]}, 32'h7);
        @(negedge clk);
        checkOutput($sformatf("u%0d_done_one_cycle", idx), done_v[idx], 32'd0);
      end
    end
  endtask

  initial frameMonitor(0, 8, 1, 16, 0);
  initial frameMonitor(1, 8, 1, 16, 1);
  initial frameMonitor(2, 8, 1, 16, 2);
  initial frameMonitor(3, 7, 2, 4, 0);

  initial begin
    int k, k1;
    bit d_ok;
    for (int i = 0; i < 4; i++) data_v[i] = '0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("u%0d_reset_tx_rdy_busy_done", i),
                  {tx_v[i], ready_v[i], busy_v[i], done_v[i]}, 32'hC);
    n_rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic frames on every configuration, including both parity senses.
    applyStimulus(0, 9'h0A5, 1'b0, -1, 1'b0, k);
    applyStimulus(1, 9'h007, 1'b1, -1, 1'b0, k);
    applyStimulus(2, 9'h007, 1'b0, -1, 1'b0, k);
    applyStimulus(3, 9'h041, 1'b0, -1, 1'b0, k);
    applyStimulus(1, 9'h003, 1'b0, -1, 1'b0, k);
    applyStimulus(2, 9'h080, 1'b0, -1, 1'b0, k);
    applyStimulus(2, 9'h000, 1'b1, -1, 1'b0, k);
    applyStimulus(3, 9'h07F, 1'b0, -1, 1'b0, k);

    // Back-to-back with valid held: second start must be exactly one idle cycle later.
    applyStimulus(0, 9'h055, 1'b0, -1, 1'b1, k1);
    applyStimulus(0, 9'h0AA, 1'b0, k1 + 161, 1'b0, k);

    // Mid-frame data change and valid pulse must not alter or add frames.
    applyStimulus(0, 9'h0C3, 1'b0, -1, 1'b0, k);
    while (cyc < k + 50) @(negedge clk);
    valid_v[0] = 1'b1;
    data_v[0]  = 9'h03C;
    @(negedge clk);
    valid_v[0] = 1'b0;
    data_v[0]  = 9'h0FF;
    waitIdle();

    // Reset during data bit 3 abandons the frame at once.
    applyStimulus(0, 9'h0F0, 1'b0, -1, 1'b0, k);
    while (cyc < k + 70) @(negedge clk);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("u0_midframe_reset_tx_rdy_busy_done",
                {tx_v[0], ready_v[0], busy_v[0], done_v[0]}, 32'hC);
    repeat (3) @(negedge clk);
    n_rst = 1'b1;
    d_ok = 1'b1;
    repeat (40) begin
      @(negedge clk);
      if (done_v[0] !== 1'b0 || tx_v[0] !== 1'b1) d_ok = 1'b0;
    end
    checkOutput("u0_no_done_after_reset", d_ok, 32'd1);
    applyStimulus(0, 9'h03C, 1'b0, -1, 1'b0, k);
    waitIdle();

    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("u%0d_frames_outstanding", i), qSize(i), 32'd0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
